// File: rtl/csr_pkg.sv
// Shared definitions for the CSR access unit: addresses, op/state encodings,
// the latched request payload and address-class helpers.
package csr_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 12;

   localparam logic [AW-1:0] CSR_CYCLE    = 12'hC00;
   localparam logic [AW-1:0] CSR_TIME     = 12'hC01;
   localparam logic [AW-1:0] CSR_INSTRET  = 12'hC02;
   localparam logic [AW-1:0] CSR_CYCLEH   = 12'hC80;
   localparam logic [AW-1:0] CSR_TIMEH    = 12'hC81;
   localparam logic [AW-1:0] CSR_INSTRETH = 12'hC82;
   localparam logic [AW-1:0] CSR_MSCRATCH = 12'h340;
   localparam logic [AW-1:0] CSR_MTVEC    = 12'h305;
   localparam logic [AW-1:0] CSR_MEPC     = 12'h341;
   localparam logic [AW-1:0] CSR_MCAUSE   = 12'h342;

   typedef enum logic [1:0] {
      OP_RESERVED = 2'b00,
      OP_RW       = 2'b01,
      OP_RS       = 2'b10,
      OP_RC       = 2'b11
   } csr_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_READ = 2'b01,
      ST_DONE = 2'b10
   } csr_state_t;

   typedef struct packed {
      csr_op_t         op;
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] src;
      logic            rs1_zero;
   } csr_req_t;

   function automatic logic is_counter(input logic [AW-1:0] a);
      return a inside {CSR_CYCLE, CSR_TIME, CSR_INSTRET,
                       CSR_CYCLEH, CSR_TIMEH, CSR_INSTRETH};
   endfunction

   function automatic logic is_mreg(input logic [AW-1:0] a);
      return a inside {CSR_MSCRATCH, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE};
   endfunction

endpackage

// File: rtl/csr_mregs.sv
// Machine CSR storage (mscratch, mtvec, mepc, mcause) with an instruction
// write port, a trap port that wins on mepc/mcause, and an address read mux.
module csr_mregs
   import csr_pkg::*;
#(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [AW-1:0]   rd_addr,
   output logic [XLEN-1:0] rd_data_c,
   output logic [XLEN-1:0] mtvec,
   output logic [XLEN-1:0] mepc
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   logic [XLEN-1:0] mscratch;
   logic [XLEN-1:0] mcause;

   // Trap commit overrides any same-cycle instruction write to mepc/mcause.
   always_ff @(posedge clk) begin
      if (reset) begin
         mscratch <= '0;
         mtvec    <= MTVEC_RESET & ALIGN_MASK;
         mepc     <= '0;
         mcause   <= '0;
      end else begin
         if (wr_en && wr_addr == CSR_MSCRATCH) mscratch <= wr_data;
         if (wr_en && wr_addr == CSR_MTVEC)    mtvec    <= wr_data & ALIGN_MASK;
         if (trap_valid) begin
            mepc   <= trap_pc & ALIGN_MASK;
            mcause <= trap_cause;
         end else begin
            if (wr_en && wr_addr == CSR_MEPC)   mepc   <= wr_data & ALIGN_MASK;
            if (wr_en && wr_addr == CSR_MCAUSE) mcause <= wr_data;
         end
      end
   end

   always_comb begin
      rd_data_c = '0;
      case (rd_addr)
         CSR_MSCRATCH: rd_data_c = mscratch;
         CSR_MTVEC:    rd_data_c = mtvec;
         CSR_MEPC:     rd_data_c = mepc;
         CSR_MCAUSE:   rd_data_c = mcause;
         default:      rd_data_c = '0;
      endcase
   end

endmodule

// File: rtl/csr_access_unit.sv
// Execute-stage Zicsr unit: accepts one CSR instruction, reads the old value
// (local register or counter block), applies RW/RS/RC and returns the old value.
module csr_access_unit
   import csr_pkg::*;
#(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [11:0] req_addr,
   input  logic [31:0] req_src,
   input  logic        req_rs1_zero,
   output logic [11:0] cnt_addr,
   input  logic [31:0] cnt_rdata,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_illegal,
   input  logic        trap_valid,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_cause,
   output logic [31:0] mtvec_out,
   output logic [31:0] mepc_out
);

   csr_state_t      state, next_state;
   csr_req_t        lat;
   logic            wr_en_c, illegal_c, local_wr_c, is_cnt_c, is_mreg_c;
   logic [XLEN-1:0] old_c, new_c, mreg_rdata_c;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (req_valid) next_state = ST_READ;
         ST_READ: next_state = ST_DONE;
         ST_DONE: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Old-value select, legality and read-modify-write for the latched request.
   always_comb begin
      cnt_addr   = (state == ST_IDLE) ? req_addr : lat.addr;
      is_cnt_c   = is_counter(lat.addr);
      is_mreg_c  = is_mreg(lat.addr);
      wr_en_c    = (lat.op == OP_RW) || !lat.rs1_zero;
      illegal_c  = (lat.op == OP_RESERVED) || !(is_cnt_c || is_mreg_c) ||
                   (wr_en_c && lat.addr[11:10] == 2'b11);
      old_c      = is_cnt_c ? cnt_rdata : mreg_rdata_c;
      new_c      = lat.src;
      case (lat.op)
         OP_RS:   new_c = old_c | lat.src;
         OP_RC:   new_c = old_c & ~lat.src;
         default: new_c = lat.src;
      endcase
      local_wr_c = (state == ST_READ) && wr_en_c && !illegal_c && is_mreg_c;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lat          <= '0;
         req_ready    <= 1'b1;
         resp_valid   <= 1'b0;
         resp_data    <= '0;
         resp_illegal <= 1'b0;
      end else begin
         if (state == ST_IDLE && req_valid) begin
            lat.op       <= csr_op_t'(req_op);
            lat.addr     <= req_addr;
            lat.src      <= req_src;
            lat.rs1_zero <= req_rs1_zero;
         end
         req_ready  <= (next_state == ST_IDLE);
         resp_valid <= (state == ST_READ);
         if (state == ST_READ) begin
            resp_data    <= illegal_c ? '0 : old_c;
            resp_illegal <= illegal_c;
         end
      end
   end

   csr_mregs #(
      .MTVEC_RESET (MTVEC_RESET)
   ) u_mregs (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (local_wr_c),
      .wr_addr    (lat.addr),
      .wr_data    (new_c),
      .trap_valid (trap_valid),
      .trap_pc    (trap_pc),
      .trap_cause (trap_cause),
      .rd_addr    (lat.addr),
      .rd_data_c  (mreg_rdata_c),
      .mtvec      (mtvec_out),
      .mepc       (mepc_out)
   );

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a free-running counter-block model.
module tb_csr_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [11:0] req_addr;
   logic [31:0] req_src;
   logic        req_rs1_zero;
   logic [11:0] cnt_addr;
   logic [31:0] cnt_rdata;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_illegal;
   logic        trap_valid;
   logic [31:0] trap_pc;
   logic [31:0] trap_cause;
   logic [31:0] mtvec_out;
   logic [31:0] mepc_out;

   logic [31:0] cnt_val;
   int          n_checks = 0;
   int          n_errors = 0;

   logic [31:0] rdata;
   logic        rill;
   logic [31:0] csnap;

   always #5 clk = ~clk;

   csr_access_unit #(
      .MTVEC_RESET (32'h0000_1003)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_addr     (req_addr),
      .req_src      (req_src),
      .req_rs1_zero (req_rs1_zero),
      .cnt_addr     (cnt_addr),
      .cnt_rdata    (cnt_rdata),
      .resp_valid   (resp_valid),
      .resp_data    (resp_data),
      .resp_illegal (resp_illegal),
      .trap_valid   (trap_valid),
      .trap_pc      (trap_pc),
      .trap_cause   (trap_cause),
      .mtvec_out    (mtvec_out),
      .mepc_out     (mepc_out)
   );

   // Counter block: registered read data mixes the sampled address into the count.
   always @(posedge clk) begin
      if (reset) begin
         cnt_val   <= '0;
         cnt_rdata <= '0;
      end else begin
         cnt_val   <= cnt_val + 32'd1;
         cnt_rdata <= cnt_val ^ {20'h0, cnt_addr};
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One request with latency checks; optional trap pulse during the READ cycle.
   task automatic do_req(input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] src, input logic rs1z, input logic trap,
                         output logic [31:0] data, output logic ill,
                         output logic [31:0] csnap_o);
      @(negedge clk);
      check("ready_before", 32'(req_ready), 32'd1);
      req_valid    = 1'b1;
      req_op       = op;
      req_addr     = addr;
      req_src      = src;
      req_rs1_zero = rs1z;
      csnap_o      = cnt_val;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("valid_accept_plus1", 32'(resp_valid), 32'd0);
      check("ready_busy", 32'(req_ready), 32'd0);
      if (trap) trap_valid = 1'b1;
      @(posedge clk);
      #1;
      trap_valid = 1'b0;
      check("valid_accept_plus2", 32'(resp_valid), 32'd1);
      data = resp_data;
      ill  = resp_illegal;
      @(posedge clk);
      #1;
      check("valid_one_cycle", 32'(resp_valid), 32'd0);
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = '0;
      req_src = '0; req_rs1_zero = 1'b0; trap_valid = 1'b0;
      trap_pc = '0; trap_cause = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mtvec", mtvec_out, 32'h0000_1000);
      check("rst_mepc", mepc_out, 32'h0);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // mscratch read-modify-write chain
      do_req(2'b01, 12'h340, 32'hDEAD_BEEF, 1'b0, 1'b0, rdata, rill, csnap);
      check("rw_mscratch_data", rdata, 32'h0);
      check("rw_mscratch_ill", 32'(rill), 32'd0);
      do_req(2'b10, 12'h340, 32'h0000_00F0, 1'b0, 1'b0, rdata, rill, csnap);
      check("rs_mscratch_data", rdata, 32'hDEAD_BEEF);
      do_req(2'b10, 12'h340, 32'h0, 1'b1, 1'b0, rdata, rill, csnap);
      check("rd_mscratch", rdata, 32'hDEAD_BEFF);

      // counter reads: legal when write suppressed, illegal otherwise
      do_req(2'b10, 12'hC00, 32'h0, 1'b1, 1'b0, rdata, rill, csnap);
      check("cycle_data", rdata, csnap ^ 32'h0000_0C00);
      check("cycle_ill", 32'(rill), 32'd0);
      do_req(2'b10, 12'hC00, 32'h5, 1'b0, 1'b0, rdata, rill, csnap);
      check("cycle_wr_ill", 32'(rill), 32'd1);
      check("cycle_wr_data", rdata, 32'h0);
      do_req(2'b11, 12'hC82, 32'h0, 1'b1, 1'b0, rdata, rill, csnap);
      check("instreth_data", rdata, csnap ^ 32'h0000_0C82);
      check("instreth_ill", 32'(rill), 32'd0);
      do_req(2'b01, 12'hC01, 32'h0, 1'b1, 1'b0, rdata, rill, csnap);
      check("time_rw_ill", 32'(rill), 32'd1);

      // mtvec write and clear with low-bit masking
      do_req(2'b01, 12'h305, 32'h8000_1000, 1'b0, 1'b0, rdata, rill, csnap);
      check("rw_mtvec_old", rdata, 32'h0000_1000);
      do_req(2'b11, 12'h305, 32'h0000_1FFF, 1'b0, 1'b0, rdata, rill, csnap);
      check("rc_mtvec_old", rdata, 32'h8000_1000);
      check("rc_mtvec_out", mtvec_out, 32'h8000_0000);

      // illegal op / address leave state untouched
      do_req(2'b00, 12'h340, 32'h1, 1'b0, 1'b0, rdata, rill, csnap);
      check("op00_ill", 32'(rill), 32'd1);
      check("op00_data", rdata, 32'h0);
      do_req(2'b01, 12'h7FF, 32'h1, 1'b0, 1'b0, rdata, rill, csnap);
      check("addr7ff_ill", 32'(rill), 32'd1);
      do_req(2'b10, 12'h340, 32'h0, 1'b1, 1'b0, rdata, rill, csnap);
      check("mscratch_kept", rdata, 32'hDEAD_BEFF);
      check("mtvec_kept", mtvec_out, 32'h8000_0000);
      do_req(2'b01, 12'h305, 32'h1234_5677, 1'b0, 1'b0, rdata, rill, csnap);
      check("mtvec_mask", mtvec_out, 32'h1234_5674);

      // trap in READ beats the instruction write to mepc
      trap_pc = 32'h0000_4006; trap_cause = 32'h8000_000B;
      do_req(2'b01, 12'h341, 32'h0000_1234, 1'b0, 1'b1, rdata, rill, csnap);
      check("trap_old_mepc", rdata, 32'h0);
      check("trap_mepc_out", mepc_out, 32'h0000_4004);
      do_req(2'b10, 12'h342, 32'h0, 1'b1, 1'b0, rdata, rill, csnap);
      check("trap_mcause", rdata, 32'h8000_000B);
      do_req(2'b01, 12'h341, 32'h0000_1237, 1'b0, 1'b0, rdata, rill, csnap);
      check("mepc_old", rdata, 32'h0000_4004);
      check("mepc_mask", mepc_out, 32'h0000_1234);

      // reset while a request sits in READ
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b01; req_addr = 12'h340; req_src = 32'h5;
      req_rs1_zero = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      reset     = 1'b1;
      @(posedge clk);
      #1;
      check("rstread_valid", 32'(resp_valid), 32'd0);
      check("rstread_ready", 32'(req_ready), 32'd1);
      check("rstread_mtvec", mtvec_out, 32'h0000_1000);
      check("rstread_mepc", mepc_out, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("rstread_no_resp", 32'(resp_valid), 32'd0);
      do_req(2'b10, 12'h340, 32'h0, 1'b1, 1'b0, rdata, rill, csnap);
      check("rstread_mscratch", rdata, 32'h0);
      do_req(2'b10, 12'h342, 32'h0, 1'b1, 1'b0, rdata, rill, csnap);
      check("rstread_mcause", rdata, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
